interrupt_acknowledge_master: RTL and testbench
===============================================

Name: interrupt_acknowledge_master

Overview:
- CPU-side initiator of the interrupt-acknowledge protocol: the counterpart to the 8259 request and priority logic.
- Watches the INT line from the controller and, when enabled, generates the 8086-style INTA pulse train.
- Captures the vector byte that the controller drives on the data bus and presents it to the CPU core model with a one-cycle valid strobe.
- Used as the bus-master stimulus and checker partner for the full KF8259 top.

Parameters:
- INTA_LOW_CYCLES, 2, clock cycles each INTA pulse is held low (≥1).
- INTA_GAP_CYCLES, 2, high cycles between pulses and post-sequence holdoff (≥1).

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- interrupt  input  1  INT from the controller, active-high, synchronous to clock
- interrupt_enable  input  1  CPU IF flag; 0 blocks new sequences
- data_bus_in  input  8  controller data bus, valid during INTA low
- interrupt_acknowledge_n  output  1  INTA, active-low, registered
- vector  output  8  captured vector byte, registered, held until next capture
- vector_valid  output  1  one-cycle strobe when vector updates
- busy  output  1  high from sequence start through holdoff end

Behaviour:
- Reset values: interrupt_acknowledge_n=1, vector=8'h00, vector_valid=0, busy=0, state=IDLE, counter=0.
- Reset mid-sequence returns interrupt_acknowledge_n to 1 immediately (asynchronous); no partial vector is ever reported.
- The cycle counter is sized $clog2(max(L,G))+1, where L=INTA_LOW_CYCLES and G=INTA_GAP_CYCLES.
- FSM states: IDLE, PULSE1, GAP1, PULSE2, DONE, HOLDOFF. PULSE3 and GAP2 exist only with the optional feature.
- IDLE: when interrupt=1 and interrupt_enable=1 are sampled at edge N, go to PULSE1. interrupt_acknowledge_n=0 and busy=1 from cycle N+1.
- PULSE1: interrupt_acknowledge_n=0 for L cycles. data_bus_in is ignored. Then go to GAP1.
- GAP1: interrupt_acknowledge_n=1 for G cycles, then go to PULSE2.
- PULSE2: interrupt_acknowledge_n=0 for L cycles. data_bus_in is captured into vector on the edge ending the last low cycle. Then go to DONE.
- DONE: one cycle. interrupt_acknowledge_n=1, vector_valid=1. Then go to HOLDOFF.
- HOLDOFF: G cycles with busy=1 and no new request accepted. Then go to IDLE with busy=0.
- Default-parameter timeline, request seen at cycle 0:
  - INTA low in cycles 1-2 and 5-6;
  - data sampled at the end of cycle 6;
  - vector_valid in cycle 7;
  - holdoff in cycles 8-9;
  - earliest next acceptance at the edge ending cycle 10.
- Once started, a sequence always completes. Deasserting interrupt or interrupt_enable mid-sequence has no effect. A spurious (IR7) vector supplied by the controller is reported like any other vector.
- interrupt high while in HOLDOFF is not lost: if it is still high when IDLE samples it, a new sequence starts.
- interrupt_enable=0 in IDLE: no INTA activity, busy stays 0.
- Simultaneous interrupt rise and interrupt_enable rise at the same edge: the sequence starts.

Optional Feature:
- Macro: KF8259_INTA_8080_MODE_EN.
- Defined, PULSE1 behaviour: the byte captured in PULSE1 (CALL opcode, normally 8'hCD) is stored in an extra output opcode[7:0].
- Defined, PULSE2 behaviour: PULSE2 captures the low address byte into vector[7:0].
- Defined, third pulse: GAP2 (G cycles) and PULSE3 (L cycles) follow PULSE2. PULSE3 captures the high address byte into an extra output vector_high[7:0].
- Defined, strobe: vector_valid fires once, after PULSE3.
- Defined, outputs and reset: the extra ports exist only when the macro is defined, and both reset to 8'h00.
- Not defined: 8086 two-pulse behaviour only; no extra ports.

Test Plan:
- Reset, then interrupt=1, interrupt_enable=1, data_bus_in=8'h48 during pulse 2 → INTA low in cycles 1-2 and 5-6, vector=8'h48, vector_valid=1 only in cycle 7, busy=0 from cycle 10.
- interrupt_enable=0 with interrupt=1 for 20 cycles → interrupt_acknowledge_n stays 1, busy=0, vector_valid never asserts.
- data_bus_in=8'hAA during pulse 1 and 8'h55 during pulse 2 → vector=8'h55 (pulse-1 data ignored).
- interrupt dropped to 0 in cycle 2 → sequence still completes and vector_valid pulses in cycle 7. interrupt held high through holdoff → second sequence's first INTA low at cycle 11.
- reset asserted in cycle 5 (INTA low) → interrupt_acknowledge_n=1 in the same cycle, vector stays 8'h00, no vector_valid, and a new request after reset release is accepted normally.
- With KF8259_INTA_8080_MODE_EN, bytes 8'hCD / 8'h20 / 8'h01 on the three pulses → opcode=8'hCD, vector=8'h20, vector_high=8'h01, a single vector_valid after the third pulse.

Source files
------------

// File: rtl/interrupt_acknowledge_master.sv
// CPU-side INTA initiator: pulses INTA, captures the vector, strobes valid.
// Optional macro KF8259_INTA_8080_MODE_EN adds a third pulse (opcode/high byte).
module interrupt_acknowledge_master #(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt,
  input  logic       interrupt_enable,
  input  logic [7:0] data_bus_in,
  output logic       interrupt_acknowledge_n,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       busy
`ifdef KF8259_INTA_8080_MODE_EN
  ,
  output logic [7:0] opcode,
  output logic [7:0] vector_high
`endif
);

  localparam int MAXC =
    (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ?
    INTA_LOW_CYCLES : INTA_GAP_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] L_LAST =
    CW'(INTA_LOW_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST =
    CW'(INTA_GAP_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PULSE1,
    GAP1,
    PULSE2,
    DONE,
    HOLDOFF
`ifdef KF8259_INTA_8080_MODE_EN
    ,
    GAP2,
    PULSE3
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            inta_n_q, inta_n_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [7:0]      vector_q;
  logic            lo_end, gap_end;

  assign lo_end  = (cnt_q == L_LAST);
  assign gap_end = (cnt_q == G_LAST);

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (interrupt && interrupt_enable) begin
          state_d = PULSE1;
          cnt_d   = '0;
        end
      end
      PULSE1: begin
        if (lo_end) begin
          state_d = GAP1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      GAP1: begin
        if (gap_end) begin
          state_d = PULSE2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      PULSE2: begin
        if (lo_end) begin
`ifdef KF8259_INTA_8080_MODE_EN
          state_d = GAP2;
`else
          state_d = DONE;
`endif
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
`ifdef KF8259_INTA_8080_MODE_EN
      GAP2: begin
        if (gap_end) begin
          state_d = PULSE3;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      PULSE3: begin
        if (lo_end) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
`endif
      DONE: begin
        state_d = HOLDOFF;
        cnt_d   = '0;
      end
      HOLDOFF: begin
        if (gap_end) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    inta_n_d = 1'b1;
    if (state_d == PULSE1 || state_d == PULSE2)
      inta_n_d = 1'b0;
`ifdef KF8259_INTA_8080_MODE_EN
    if (state_d == PULSE3)
      inta_n_d = 1'b0;
`endif
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  // State, counter and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      inta_n_q <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      inta_n_q <= inta_n_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  // Vector capture on the edge ending the last low cycle of PULSE2
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vector_q <= 8'h00;
    end else if (state_q == PULSE2 && lo_end) begin
      vector_q <= data_bus_in;
    end
  end

`ifdef KF8259_INTA_8080_MODE_EN
  logic [7:0] opcode_q, vector_high_q;

  // Opcode byte from PULSE1, high address byte from PULSE3
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opcode_q      <= 8'h00;
      vector_high_q <= 8'h00;
    end else begin
      if (state_q == PULSE1 && lo_end)
        opcode_q <= data_bus_in;
      if (state_q == PULSE3 && lo_end)
        vector_high_q <= data_bus_in;
    end
  end

  assign opcode      = opcode_q;
  assign vector_high = vector_high_q;
`endif

  assign interrupt_acknowledge_n = inta_n_q;
  assign vector                  = vector_q;
  assign vector_valid            = valid_q;
  assign busy                    = busy_q;

endmodule

// File: tb/tb_interrupt_acknowledge_master.sv
// Bench for interrupt_acknowledge_master: timeline model vs DUT.
// Honors KF8259_INTA_8080_MODE_EN when defined.
module tb_interrupt_acknowledge_master;

  localparam int L = 2;
  localparam int G = 2;
`ifdef KF8259_INTA_8080_MODE_EN
  localparam int NP = 3;
`else
  localparam int NP = 2;
`endif
  localparam int D = NP * L + (NP - 1) * G + 1;

  logic       clock;
  logic       reset;
  logic       interrupt;
  logic       interrupt_enable;
  logic [7:0] data_bus_in;
  logic       interrupt_acknowledge_n;
  logic [7:0] vector;
  logic       vector_valid;
  logic       busy;
`ifdef KF8259_INTA_8080_MODE_EN
  logic [7:0] opcode;
  logic [7:0] vector_high;
`endif

  interrupt_acknowledge_master #(
    .INTA_LOW_CYCLES(L),
    .INTA_GAP_CYCLES(G)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .interrupt               (interrupt),
    .interrupt_enable        (interrupt_enable),
    .data_bus_in             (data_bus_in),
    .interrupt_acknowledge_n (interrupt_acknowledge_n),
    .vector                  (vector),
    .vector_valid            (vector_valid),
    .busy                    (busy)
`ifdef KF8259_INTA_8080_MODE_EN
    ,
    .opcode                  (opcode),
    .vector_high             (vector_high)
`endif
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int start = -1000;
  logic [7:0] ev  = 8'h00;
  logic [7:0] eop = 8'h00;
  logic [7:0] evh = 8'h00;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d observed %h expected %h",
             tag, cyc, obs, exp);
    end
  endtask

  function automatic bit in_seq(input int off);
    return off >= 1 && off <= D + G;
  endfunction

  function automatic bit exp_low(input int off);
    for (int k = 0; k < NP; k++)
      if (off >= k * (L + G) + 1 && off <= k * (L + G) + L)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic cmp();
    int off;
    bit act;
    off = cyc - start;
    act = in_seq(off);
    chk("inta_n", {7'd0, interrupt_acknowledge_n},
        {7'd0, !(act && exp_low(off))});
    chk("busy", {7'd0, busy}, {7'd0, act});
    chk("valid", {7'd0, vector_valid},
        {7'd0, act && off == D});
    chk("vector", vector, ev);
`ifdef KF8259_INTA_8080_MODE_EN
    chk("opcode", opcode, eop);
    chk("vector_high", vector_high, evh);
`endif
  endtask

  task automatic cycle(input logic i,
                       input logic e,
                       input logic [7:0] d);
    int off;
    bit act;
    cmp();
    interrupt        = i;
    interrupt_enable = e;
    data_bus_in      = d;
    off = cyc - start;
    act = in_seq(off);
    if (act) begin
      for (int k = 0; k < NP; k++) begin
        if (off == k * (L + G) + L) begin
`ifdef KF8259_INTA_8080_MODE_EN
          if (k == 0) eop = d;
          if (k == 1) ev  = d;
          if (k == 2) evh = d;
`else
          if (k == 1) ev = d;
`endif
        end
      end
    end
    if (!act && i && e) start = cyc;
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic mid_reset();
    cmp();
    interrupt        = 1'b0;
    interrupt_enable = 1'b0;
    reset            = 1'b1;
    #1;
    start = -1000;
    ev    = 8'h00;
    eop   = 8'h00;
    evh   = 8'h00;
    chk("rst_inta_n", {7'd0, interrupt_acknowledge_n}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_valid", {7'd0, vector_valid}, 8'd0);
    chk("rst_vector", vector, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    cyc++;
  endtask

  function automatic logic [7:0] pulse_byte(input int off,
                                            input logic [7:0] b0,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2);
    if (off <= L) return b0;
    if (off <= 2 * L + G) return b1;
    return b2;
  endfunction

  initial begin
    clock            = 1'b0;
    reset            = 1'b1;
    interrupt        = 1'b0;
    interrupt_enable = 1'b0;
    data_bus_in      = 8'h00;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    cycle(1'b1, 1'b1, 8'h00);
    for (int n = 0; n < D + G + 2; n++)
      cycle(1'b0, 1'b1, 8'h48);

    for (int n = 0; n < 20; n++)
      cycle(1'b1, 1'b0, 8'h5A);

    cycle(1'b1, 1'b1, 8'hAA);
    for (int n = 0; n < D + G + 2; n++)
      cycle(1'b0, 1'b1,
            (cyc - start > L) ? 8'h55 : 8'hAA);

    cycle(1'b1, 1'b1, 8'h11);
    for (int n = 0; n < 2 * (D + G) + 4; n++) begin
      int off;
      off = cyc - start;
      cycle(!(off >= 1 && off < 4 && n < 4), 1'b1,
            8'(8'h30 + n));
    end
    for (int n = 0; n < D + G + 2; n++)
      cycle(1'b0, 1'b0, 8'h00);

    cycle(1'b1, 1'b1, 8'h77);
    while (cyc - start < 5)
      cycle(1'b0, 1'b1, 8'h77);
    mid_reset();
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h00);
    for (int n = 0; n < D + G + 2; n++)
      cycle(1'b0, 1'b1, 8'h3C);

    cycle(1'b1, 1'b1, 8'h00);
    for (int n = 0; n < D + G + 2; n++)
      cycle(1'b0, 1'b1,
            pulse_byte(cyc - start, 8'hCD, 8'h20, 8'h01));

    for (int n = 0; n < 400; n++)
      cycle(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 4) != 0),
            8'($urandom));

    cmp();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
